// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sync, ghost rejection, debounce.
// Optional hex-entry shift register enabled by KEYPAD_HEX_ENTRY_EN.
module keypad_scan #(
    parameter int SCAN_DIV       = 131072,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  col,
    input  logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] entry
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_SCANS);

    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] div_q;
    logic [1:0]    idx_q;
    logic [3:0]    col_q;
    logic [1:0]    acc_n_q;
    logic [3:0]    acc_code_q;
    logic [4:0]    prev_q;
    logic [CW-1:0] stable_q, stable_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;

    logic          sample, scan_end;
    logic [2:0]    zeros;
    logic [1:0]    hit_row;
    logic [2:0]    n_sum;
    logic [1:0]    tot_n;
    logic [3:0]    tot_code;
    logic [4:0]    result;

    function automatic logic [3:0] keymap(input logic [1:0] r,
                                          input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        unique case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'h0;
            4'hD: k = 4'hF;
            4'hE: k = 4'hE;
            4'hF: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    assign sample   = (div_q == DIV_LAST);
    assign scan_end = sample && (idx_q == 2'd3);

    always_comb begin
        zeros   = 3'd0;
        hit_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                zeros   = zeros + 3'd1;
                hit_row = 2'(r);
            end
        end
    end

    // Running press count saturates at 2: anything above one key is NONE.
    always_comb begin
        n_sum    = {1'b0, acc_n_q} + zeros;
        tot_n    = (n_sum >= 3'd2) ? 2'd2 : n_sum[1:0];
        tot_code = (zeros == 3'd1) ? keymap(hit_row, idx_q) : acc_code_q;
        result   = (tot_n == 2'd1) ? {1'b1, tot_code} : 5'd0;
        stable_d = CW'(1);
        if (result == prev_q) begin
            stable_d = (stable_q == DB_MAX) ? stable_q : stable_q + CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (scan_end && stable_d == DB_MAX) begin
            unique case (state_q)
                IDLE: begin
                    if (result[4]) begin
                        code_d  = result[3:0];
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        state_d = PRESSED;
                    end
                end
                PRESSED: begin
                    if (!result[4]) begin
                        held_d  = 1'b0;
                        state_d = IDLE;
                    end else if (result[3:0] != code_q) begin
                        code_d  = result[3:0];
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1     <= 4'hF;
            row_s2     <= 4'hF;
            div_q      <= '0;
            idx_q      <= 2'd0;
            col_q      <= 4'b1110;
            acc_n_q    <= 2'd0;
            acc_code_q <= 4'h0;
            prev_q     <= 5'd0;
            stable_q   <= '0;
            state_q    <= IDLE;
            code_q     <= 4'h0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            row_s1  <= row;
            row_s2  <= row_s1;
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            if (sample) begin
                div_q <= '0;
                idx_q <= idx_q + 2'd1;
                col_q <= ~(4'b0001 << (idx_q + 2'd1));
                if (scan_end) begin
                    acc_n_q    <= 2'd0;
                    acc_code_q <= 4'h0;
                    prev_q     <= result;
                    stable_q   <= stable_d;
                end else begin
                    acc_n_q    <= tot_n;
                    acc_code_q <= tot_code;
                end
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    assign col       = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

`ifdef KEYPAD_HEX_ENTRY_EN
    logic [15:0] entry_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= 16'h0000;
        end else if (valid_d) begin
            entry_q <= {entry_q[11:0], code_d};
        end
    end

    assign entry = entry_q;
`else
    assign entry = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a combinational 4x4 keypad model.
// Uses SCAN_DIV=4, DEBOUNCE_SCANS=2 (one full scan = 16 cycles).
module tb_keypad_scan;

    localparam int SD  = 4;
    localparam int DB  = 2;
    localparam int LAT = (DB + 1) * 4 * SD + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] entry;
    logic [15:0] pmask = 16'h0000;

    int vectors = 0;
    int miscompares = 0;
    int vcount = 0;
    logic [3:0] vcode = 4'h0;
    logic last_v = 1'b0;
    logic double_v = 1'b0;

    keypad_scan #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .col(col),
        .row(row),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held),
        .entry(entry)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pmask[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            vcount = vcount + 1;
            vcode  = key_code;
            if (last_v) double_v = 1'b1;
        end
        last_v = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_release(input string tag);
        for (int i = 0; i < LAT; i++) begin
            if (key_held == 1'b0) break;
            tick(1);
        end
        chk({tag, "_held_drop"}, 32'(key_held), 32'd0);
    endtask

    task automatic press_release(input int b, input logic [3:0] code,
                                 input string tag);
        int base;
        base  = vcount;
        pmask = 16'h0001 << b;
        tick(60);
        chk({tag, "_npulse"}, 32'(vcount - base), 32'd1);
        chk({tag, "_code"}, 32'(vcode), 32'(code));
        chk({tag, "_held"}, 32'(key_held), 32'd1);
        pmask = 16'h0000;
        wait_release(tag);
        tick(20);
        chk({tag, "_no_release_pulse"}, 32'(vcount - base), 32'd1);
    endtask

    initial begin
        int base;
        logic [3:0] ecol;
        logic [15:0] exp_entry;

        tick(3);
        chk("rst_col", 32'(col), 32'hE);
        chk("rst_code", 32'(key_code), 32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_held", 32'(key_held), 32'h0);
        chk("rst_entry", 32'(entry), 32'h0);
        reset = 1'b0;

        for (int k = 0; k < 16; k++) begin
            ecol = ~(4'b0001 << ((k / 4) % 4));
            chk($sformatf("col_seq%0d", k), 32'(col), 32'(ecol));
            tick(1);
        end
        tick(200);
        chk("idle_npulse", 32'(vcount), 32'd0);
        chk("idle_code", 32'(key_code), 32'h0);
        chk("idle_held", 32'(key_held), 32'h0);
        chk("idle_entry", 32'(entry), 32'h0);

        press_release(6, 4'h6, "key6");

        base  = vcount;
        pmask = (16'h0001 << 13) | 16'h0001;
        tick(80);
        chk("ghost_npulse", 32'(vcount - base), 32'd0);
        chk("ghost_held", 32'(key_held), 32'd0);
        pmask = 16'h0001 << 13;
        tick(60);
        chk("keyF_npulse", 32'(vcount - base), 32'd1);
        chk("keyF_code", 32'(vcode), 32'hF);
        chk("keyF_held", 32'(key_held), 32'd1);
        pmask = 16'h0000;
        wait_release("keyF");
        tick(20);

        base = vcount;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pmask = pmask ^ (16'h0001 << 11);
            tick(1);
        end
        pmask = 16'h0001 << 11;
        tick(60);
        chk("bounce_npulse", 32'(vcount - base), 32'd1);
        chk("bounce_code", 32'(vcode), 32'hC);
        chk("bounce_held", 32'(key_held), 32'd1);
        pmask = 16'h0000;
        wait_release("keyC");
        tick(20);

        base  = vcount;
        pmask = 16'h0001 << 5;
        tick(60);
        chk("key5_npulse", 32'(vcount - base), 32'd1);
        chk("key5_code", 32'(vcode), 32'h5);
        chk("key5_held", 32'(key_held), 32'd1);
        tick(5);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_col", 32'(col), 32'hE);
        chk("mid_rst_code", 32'(key_code), 32'h0);
        chk("mid_rst_valid", 32'(key_valid), 32'h0);
        chk("mid_rst_held", 32'(key_held), 32'h0);
        chk("mid_rst_entry", 32'(entry), 32'h0);
        reset = 1'b0;
        tick(31);
        chk("redeb_early_valid", 32'(key_valid), 32'd0);
        chk("redeb_early_held", 32'(key_held), 32'd0);
        tick(1);
        chk("redeb_valid", 32'(key_valid), 32'd1);
        chk("redeb_code", 32'(key_code), 32'h5);
        tick(1);
        chk("redeb_pulse_end", 32'(key_valid), 32'd0);
        chk("redeb_held", 32'(key_held), 32'd1);
        pmask = 16'h0000;
        wait_release("key5");
        tick(20);

        press_release(0, 4'h1, "key1");
        press_release(1, 4'h2, "key2");
        press_release(2, 4'h3, "key3");
        press_release(3, 4'hA, "keyA");
`ifdef KEYPAD_HEX_ENTRY_EN
        exp_entry = 16'h123A;
`else
        exp_entry = 16'h0000;
`endif
        chk("entry_final", 32'(entry), 32'(exp_entry));
        chk("valid_never_double", 32'(double_v), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
